// File: rtl/bp_stall_profile_pkg.sv
// Shared stall-reason encoding, bin map and read-FSM state type for the stall histogram.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package bp_stall_profile_pkg;

    typedef enum logic [4:0] {
        e_stall_icache_miss   = 5'd0,
        e_stall_itlb_miss     = 5'd1,
        e_stall_branch_mispred= 5'd2,
        e_stall_jalr_mispred  = 5'd3,
        e_stall_fe_queue_empty= 5'd4,
        e_stall_dcache_miss   = 5'd5,
        e_stall_dtlb_miss     = 5'd6,
        e_stall_load_dep      = 5'd7,
        e_stall_mul_dep       = 5'd8,
        e_stall_fpu_dep       = 5'd9,
        e_stall_div_busy      = 5'd10,
        e_stall_struct_hazard = 5'd11,
        e_stall_csr_fence     = 5'd12,
        e_stall_exception     = 5'd13,
        e_stall_interrupt     = 5'd14,
        e_stall_replay        = 5'd15,
        e_stall_long_haz      = 5'd16,
        e_stall_sbuf_full     = 5'd17,
        e_stall_amo_wait      = 5'd18,
        e_stall_debug         = 5'd19,
        e_stall_misc          = 5'd20
    } bp_stall_reason_e;

    typedef enum logic {
        e_rd_idle  = 1'b0,
        e_rd_valid = 1'b1
    } bp_stall_rd_state_e;

    localparam int num_stall_reasons_gp = 21;
    localparam int instr_bin_gp         = 21;
    localparam int unknown_bin_gp       = 22;
    localparam int total_addr_gp        = 23;

    // Commit wins over any stall flag; out-of-range reasons fall into the unknown bin.
    function automatic logic [4:0] bp_stall_classify(input logic       commit_v,
                                                     input logic       stall_v,
                                                     input logic [4:0] reason);
        if (commit_v)
            return 5'(instr_bin_gp);
        else if (stall_v && (reason <= 5'(num_stall_reasons_gp - 1)))
            return reason;
        else
            return 5'(unknown_bin_gp);
    endfunction

endpackage

// File: rtl/bp_stall_sat_counter.sv
// Histogram bin counter; BP_STALL_HIST_SATURATE_EN selects saturate-at-all-ones, else wrap.
// Latency: increment lands on the next edge; count_o is the post-edge value ignoring clear.
// Backpressure: none; limit_o pulses whenever an increment hits or crosses the limit.
module bp_stall_sat_counter #(
    parameter int counter_width_p = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_li,
    input  logic                       up_i,
    input  logic                       clear_i,
    output logic [counter_width_p-1:0] count_o,
    output logic                       limit_o
);

    localparam logic [counter_width_p-1:0] max_lp = '1;

    logic [counter_width_p-1:0] count_r;
    logic                       at_max;

    assign at_max = (count_r == max_lp);

`ifdef BP_STALL_HIST_SATURATE_EN
    assign count_o = (up_i && !at_max) ? count_r + counter_width_p'(1) : count_r;
    assign limit_o = up_i && (count_o == max_lp);
`else
    assign count_o = count_r + counter_width_p'(up_i);
    assign limit_o = up_i && at_max;
`endif

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li)
            count_r <= '0;
        else if (clear_i)
            count_r <= '0;
        else
            count_r <= count_o;
    end

endmodule

// File: rtl/bp_stall_histogram.sv
// Stall-attribution histogram (instr/per-reason/unknown bins + total) with a readable shadow bank; mode via BP_STALL_HIST_SATURATE_EN.
// Latency: sample to live bin two edges; read accept to rd_v_o one edge.
// Backpressure: rd_ready_o low while a result waits for rd_yumi_i; sampling never stalls.
module bp_stall_histogram
    import bp_stall_profile_pkg::*;
#(
    parameter int counter_width_p = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_li,
    input  logic                       freeze_i,
    input  logic                       commit_v_i,
    input  logic                       stall_v_i,
    input  logic [4:0]                 stall_reason_i,
    input  logic                       clear_i,
    input  logic                       snapshot_i,
    input  logic                       rd_v_i,
    input  logic [4:0]                 rd_addr_i,
    output logic                       rd_ready_o,
    output logic                       rd_v_o,
    output logic [counter_width_p-1:0] rd_data_o,
    input  logic                       rd_yumi_i,
    output logic                       overflow_o
);

    localparam int num_bins_lp = 23;
    localparam int num_ctr_lp  = num_bins_lp + 1;

    logic       s0_freeze_r;
    logic       s0_commit_r;
    logic       s0_stall_r;
    logic [4:0] s0_reason_r;

    // S0 resets to frozen so nothing is counted from the reset state.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            s0_freeze_r <= 1'b1;
            s0_commit_r <= 1'b0;
            s0_stall_r  <= 1'b0;
            s0_reason_r <= '0;
        end else begin
            s0_freeze_r <= freeze_i;
            s0_commit_r <= commit_v_i;
            s0_stall_r  <= stall_v_i;
            s0_reason_r <= stall_reason_i;
        end
    end

    logic [4:0]            bin_sel;
    logic [num_ctr_lp-1:0] up_vec;

    assign bin_sel = bp_stall_classify(s0_commit_r, s0_stall_r, s0_reason_r);

    always_comb begin
        up_vec = '0;
        if (!s0_freeze_r) begin
            up_vec[bin_sel]       = 1'b1;
            up_vec[total_addr_gp] = 1'b1;
        end
    end

    logic [counter_width_p-1:0] count_next [num_ctr_lp];
    logic [num_ctr_lp-1:0]      limit_vec;

    for (genvar i = 0; i < num_ctr_lp; i++) begin : g_ctr
        bp_stall_sat_counter #(
            .counter_width_p(counter_width_p)
        ) u_ctr (
            .clk_i   (clk_i),
            .reset_li(reset_li),
            .up_i    (up_vec[i]),
            .clear_i (clear_i),
            .count_o (count_next[i]),
            .limit_o (limit_vec[i])
        );
    end

    // Shadow uses the pre-clear next values, so snapshot+clear keeps the final increment.
    logic [counter_width_p-1:0] shadow_r [num_ctr_lp];

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int i = 0; i < num_ctr_lp; i++)
                shadow_r[i] <= '0;
        end else if (snapshot_i) begin
            for (int i = 0; i < num_ctr_lp; i++)
                shadow_r[i] <= count_next[i];
        end
    end

    logic overflow_r;

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li)
            overflow_r <= 1'b0;
        else if (clear_i)
            overflow_r <= 1'b0;
        else if (|limit_vec)
            overflow_r <= 1'b1;
    end

    assign overflow_o = overflow_r;

    bp_stall_rd_state_e         rd_state_r;
    bp_stall_rd_state_e         rd_state_n;
    logic                       rd_load;
    logic [counter_width_p-1:0] rd_mux;
    logic [counter_width_p-1:0] rd_data_r;

    always_comb begin
        rd_mux = '0;
        if (rd_addr_i < 5'(num_ctr_lp))
            rd_mux = shadow_r[rd_addr_i];
    end

    always_comb begin
        rd_state_n = rd_state_r;
        rd_load    = 1'b0;
        case (rd_state_r)
            e_rd_idle: begin
                if (rd_v_i) begin
                    rd_load    = 1'b1;
                    rd_state_n = e_rd_valid;
                end
            end
            e_rd_valid: begin
                if (rd_yumi_i)
                    rd_state_n = e_rd_idle;
            end
            default: rd_state_n = e_rd_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            rd_state_r <= e_rd_idle;
            rd_data_r  <= '0;
        end else begin
            rd_state_r <= rd_state_n;
            if (rd_load)
                rd_data_r <= rd_mux;
        end
    end

    assign rd_ready_o = (rd_state_r == e_rd_idle);
    assign rd_v_o     = (rd_state_r == e_rd_valid);
    assign rd_data_o  = rd_data_r;

endmodule

// File: tb/tb_bp_stall_histogram.sv
// Directed bench: a 32-bit instance and a 4-bit instance share all inputs.
module tb_bp_stall_histogram;

    logic        clk_i = 1'b0;
    logic        reset_li;
    logic        freeze_i, commit_v_i, stall_v_i, clear_i, snapshot_i;
    logic [4:0]  stall_reason_i;
    logic        rd_v_i, rd_yumi_i;
    logic [4:0]  rd_addr_i;

    logic        rd_ready_a, rd_v_a, overflow_a;
    logic [31:0] rd_data_a;
    logic        rd_ready_b, rd_v_b, overflow_b;
    logic [3:0]  rd_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] da, db;
    logic [31:0] exp_b20;

    always #5 clk_i = ~clk_i;

    bp_stall_histogram #(.counter_width_p(32)) dut_a (
        .clk_i(clk_i), .reset_li(reset_li), .freeze_i(freeze_i),
        .commit_v_i(commit_v_i), .stall_v_i(stall_v_i), .stall_reason_i(stall_reason_i),
        .clear_i(clear_i), .snapshot_i(snapshot_i), .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i),
        .rd_ready_o(rd_ready_a), .rd_v_o(rd_v_a), .rd_data_o(rd_data_a),
        .rd_yumi_i(rd_yumi_i), .overflow_o(overflow_a)
    );

    bp_stall_histogram #(.counter_width_p(4)) dut_b (
        .clk_i(clk_i), .reset_li(reset_li), .freeze_i(freeze_i),
        .commit_v_i(commit_v_i), .stall_v_i(stall_v_i), .stall_reason_i(stall_reason_i),
        .clear_i(clear_i), .snapshot_i(snapshot_i), .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i),
        .rd_ready_o(rd_ready_b), .rd_v_o(rd_v_b), .rd_data_o(rd_data_b),
        .rd_yumi_i(rd_yumi_i), .overflow_o(overflow_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
    endtask

    task automatic do_snap();
        snapshot_i = 1'b1;
        tick(1);
        snapshot_i = 1'b0;
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] qa, output logic [31:0] qb);
        int w;
        w = 0;
        while (!(rd_ready_a && rd_ready_b) && w < 8) begin
            tick(1);
            w++;
        end
        if (w >= 8) begin
            n_checks++;
            n_fail++;
            $error("FAIL rd_ready_timeout: observed 0 expected 1");
        end
        rd_v_i    = 1'b1;
        rd_addr_i = addr;
        tick(1);
        rd_v_i    = 1'b0;
        check("rd_v_o_after_accept", {31'b0, rd_v_a}, 32'd1);
        qa = rd_data_a;
        qb = {28'b0, rd_data_b};
        rd_yumi_i = 1'b1;
        tick(1);
        rd_yumi_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_li = 1'b0;
        freeze_i = 1'b1; commit_v_i = 1'b0; stall_v_i = 1'b0; stall_reason_i = '0;
        clear_i = 1'b0; snapshot_i = 1'b0;
        rd_v_i = 1'b0; rd_yumi_i = 1'b0; rd_addr_i = '0;
`ifdef BP_STALL_HIST_SATURATE_EN
        exp_b20 = 32'd15;
`else
        exp_b20 = 32'd4;
`endif
        tick(2);
        check("reset_rd_v_o",       {31'b0, rd_v_a},     32'd0);
        check("reset_rd_ready_o",   {31'b0, rd_ready_a}, 32'd1);
        check("reset_rd_data_o",    rd_data_a,           32'd0);
        check("reset_overflow_o",   {31'b0, overflow_a}, 32'd0);
        reset_li = 1'b1;
        tick(2);

        // Ten commits.
        freeze_i = 1'b0; commit_v_i = 1'b1;
        tick(10);
        freeze_i = 1'b1; commit_v_i = 1'b0;
        do_snap();
        rd(5'd21, da, db); check("t1_bin21", da, 32'd10);
        rd(5'd23, da, db); check("t1_total", da, 32'd10);
        rd(5'd0,  da, db); check("t1_bin0",  da, 32'd0);
        rd(5'd24, da, db); check("t1_addr24", da, 32'd0);
        rd(5'd31, da, db); check("t1_addr31", da, 32'd0);

        // Stall reasons: valid 16, out-of-range 27, idle.
        do_clear();
        freeze_i = 1'b0; stall_v_i = 1'b1; stall_reason_i = 5'd16;
        tick(5);
        stall_reason_i = 5'd27;
        tick(3);
        stall_v_i = 1'b0; stall_reason_i = 5'd0;
        tick(2);
        freeze_i = 1'b1;
        do_snap();
        rd(5'd16, da, db); check("t2_bin16", da, 32'd5);
        rd(5'd22, da, db); check("t2_bin22", da, 32'd5);
        rd(5'd23, da, db); check("t2_total", da, 32'd10);
        rd(5'd21, da, db); check("t2_bin21_cleared", da, 32'd0);

        // Commit has priority over a stall reason.
        do_clear();
        freeze_i = 1'b0; commit_v_i = 1'b1; stall_v_i = 1'b1; stall_reason_i = 5'd5;
        tick(4);
        freeze_i = 1'b1; commit_v_i = 1'b0; stall_v_i = 1'b0; stall_reason_i = 5'd0;
        do_snap();
        rd(5'd21, da, db); check("t3_bin21", da, 32'd4);
        rd(5'd5,  da, db); check("t3_bin5",  da, 32'd0);
        rd(5'd23, da, db); check("t3_total", da, 32'd4);

        // Frozen for 6 of 10 cycles.
        do_clear();
        commit_v_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            freeze_i = ((i % 5) < 3);
            tick(1);
        end
        freeze_i = 1'b1; commit_v_i = 1'b0;
        do_snap();
        rd(5'd23, da, db); check("t4_total", da, 32'd4);
        rd(5'd21, da, db); check("t4_bin21", da, 32'd4);
        rd(5'd22, da, db); check("t4_bin22", da, 32'd0);

        // Clear and snapshot together.
        do_clear();
        freeze_i = 1'b0; commit_v_i = 1'b1;
        tick(7);
        freeze_i = 1'b1; commit_v_i = 1'b0; clear_i = 1'b1; snapshot_i = 1'b1;
        tick(1);
        clear_i = 1'b0; snapshot_i = 1'b0;
        rd(5'd21, da, db); check("t5_shadow_bin21", da, 32'd7);
        rd(5'd23, da, db); check("t5_shadow_total", da, 32'd7);
        check("t5_overflow", {31'b0, overflow_a}, 32'd0);
        do_snap();
        rd(5'd23, da, db); check("t5_live_total", da, 32'd0);
        rd(5'd21, da, db); check("t5_live_bin21", da, 32'd0);

        // Twenty commits into the 4-bit instance.
        check("t6_overflow_b_start", {31'b0, overflow_b}, 32'd0);
        freeze_i = 1'b0; commit_v_i = 1'b1;
        tick(20);
        freeze_i = 1'b1; commit_v_i = 1'b0;
        do_snap();
        check("t6_overflow_b", {31'b0, overflow_b}, 32'd1);
        check("t6_overflow_a", {31'b0, overflow_a}, 32'd0);
        rd(5'd21, da, db);
        check("t6_a_bin21", da, 32'd20);
        check("t6_b_bin21", db, exp_b20);
        rd(5'd23, da, db);
        check("t6_b_total", db, exp_b20);
        check("t6_overflow_b_sticky", {31'b0, overflow_b}, 32'd1);
        do_clear();
        check("t6_overflow_b_cleared", {31'b0, overflow_b}, 32'd0);

        // Held read survives a snapshot.
        rd_v_i = 1'b1; rd_addr_i = 5'd21;
        tick(1);
        rd_v_i = 1'b0;
        check("t7_rd_v_o", {31'b0, rd_v_a}, 32'd1);
        check("t7_data",   rd_data_a,       32'd20);
        for (int h = 0; h < 5; h++) begin
            freeze_i   = (h >= 2);
            commit_v_i = (h < 2);
            snapshot_i = (h == 2);
            tick(1);
            check("t7_hold_data",     rd_data_a,           32'd20);
            check("t7_hold_rd_ready", {31'b0, rd_ready_a}, 32'd0);
            check("t7_hold_rd_v",     {31'b0, rd_v_a},     32'd1);
        end
        freeze_i = 1'b1; commit_v_i = 1'b0; snapshot_i = 1'b0;
        rd_yumi_i = 1'b1;
        tick(1);
        rd_yumi_i = 1'b0;
        check("t7_ready_after_yumi", {31'b0, rd_ready_a}, 32'd1);
        check("t7_v_after_yumi",     {31'b0, rd_v_a},     32'd0);
        rd(5'd21, da, db);
        check("t7_new_bin21",   da, 32'd2);
        check("t7_new_b_bin21", db, 32'd2);

        // Asynchronous reset in the middle of a read.
        rd_v_i = 1'b1; rd_addr_i = 5'd21;
        tick(1);
        rd_v_i = 1'b0;
        check("t8_rd_v_before_reset", {31'b0, rd_v_a}, 32'd1);
        #2 reset_li = 1'b0;
        #1;
        check("t8_rd_v_in_reset",     {31'b0, rd_v_a},     32'd0);
        check("t8_rd_ready_in_reset", {31'b0, rd_ready_a}, 32'd1);
        check("t8_rd_data_in_reset",  rd_data_a,           32'd0);
        tick(1);
        reset_li = 1'b1;
        tick(1);
        rd(5'd21, da, db); check("t8_shadow_after_reset", da, 32'd0);
        check("t8_overflow_after_reset", {31'b0, overflow_a}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_stall_histogram.md
# bp_stall_histogram

Downstream consumer of the core stall-attribution pipeline: takes the per-cycle commit/stall classification (commit valid, stall-reason valid, 5-bit reason code) and accumulates a histogram of retired-instruction cycles, per-reason stall cycles and unattributed cycles. A shadow snapshot bank is readable through a valid/ready port, so software or a testbench can sample it without stopping the core. It sits beside the core profiler, fed by the same delayed stall vector and commit packet.

## Interface
- counter_width_p, 32, width of every bin and of the total-cycle counter
- num_bins_lp (localparam), 23: bins 0–20 = stall reasons, 21 = instr, 22 = unknown
- clk_i  in  1  clock
- reset_li  in  1  reset, asynchronous, active-low
- freeze_i  in  1  core frozen; no sampling
- commit_v_i  in  1  instruction committed this cycle
- stall_v_i  in  1  stall reason valid this cycle
- stall_reason_i  in  5  encoded reason, 0–20 per shared enum
- clear_i  in  1  synchronous clear of live bins, total and overflow
- snapshot_i  in  1  copy live bins and total into the shadow bank
- rd_v_i  in  1  read request
- rd_addr_i  in  5  bin index; 23 = total cycles
- rd_ready_o  out  1  read request accepted when high
- rd_v_o  out  1  read data valid
- rd_data_o  out  counter_width_p  shadow value
- rd_yumi_i  in  1  consumer takes rd_data_o
- overflow_o  out  1  sticky: some live bin or total hit its limit

## Operation
- Stage S0 registers {freeze_i, commit_v_i, stall_v_i, stall_reason_i}.
- Stage S1 classifies and increments. A frozen sample increments nothing.
- Classification priority: commit → bin 21; else stall_v with reason ≤20 → bin[reason]; else (stall_v with reason >20, or no flag) → bin 22.
- Every unfrozen sample also increments the total. Invariant: total == sum of bins 0–22.
- Exactly one bin increments per unfrozen sample.
- clear_i: live bins, total, overflow_o go to 0. An increment applied in the same cycle is dropped.
- snapshot_i: shadow takes the live next-state values, so it includes that cycle's increment. If clear_i is also asserted, shadow takes the pre-clear values plus the increment, and live then clears.
- Read FSM:
  - IDLE: rd_ready_o=1. On rd_v_i, latch shadow[rd_addr_i] into the data register (addr 23 → shadow total; addr 24–31 → 0) and go to VALID.
  - VALID: rd_v_o=1, rd_ready_o=0, rd_data_o stays stable even if a snapshot occurs. On rd_yumi_i, return to IDLE.
- Reset values: all live/shadow bins and total 0, S0 zeroed (treated as frozen), FSM IDLE, rd_v_o 0, rd_data_o 0, overflow_o 0.

## Timing
- Input sampled at edge N: bin visible in live state after edge N+1.
- A snapshot at cycle N+1 includes it.
- Read accepted at edge M: rd_v_o high from M through the edge on which rd_yumi_i is seen.
- rd_ready_o returns high the cycle after yumi, giving a minimum two-cycle read turnaround.
- Reset assertion mid-read drops rd_v_o immediately (async). No partial state survives.
- All outputs are registered; nothing combinational from inputs to outputs.

## Configuration
- BP_STALL_HIST_SATURATE_EN defined: bins and total saturate at all-ones, overflow_o set when the limit is reached.
- Not defined: bins and total wrap to 0, overflow_o set on wrap.
- overflow_o is sticky in both modes and cleared only by clear_i or reset.

## Structure
- Package bp_stall_profile_pkg holds:
  - bp_stall_reason_e: 5-bit, codes 0–20, shared with the profiler.
  - Constants: num_stall_reasons_gp=21, instr_bin_gp=21, unknown_bin_gp=22, total_addr_gp=23.
- One sub-module, bp_stall_sat_counter: counter_width_p, up_i, clear_i, count_o, limit_o. Saturate/wrap is selected by the macro. It is instantiated 24 times (23 bins plus total).

## Test plan
- 10 cycles commit_v=1, then snapshot, read addr 21 → 10. Read addr 23 → 10. Read addr 0 → 0.
- 5 cycles stall_v=1 reason=16, 3 cycles reason=27, 2 idle cycles; snapshot; reads → bin16=5, bin22=5, total=10.
- commit_v and stall_v both high for 4 cycles → bin21=4, bin[reason]=0.
- freeze_i high for 6 of 10 active cycles → total=4.
- clear_i and snapshot_i together after 7 commits → shadow bin21=7, live total=0. A later snapshot reads 0.
- counter_width_p=4 with 20 commits:
  - with macro: bin21=15, overflow_o=1.
  - without macro: bin21=4, overflow_o=1.
- Hold rd_yumi_i low 5 cycles with a snapshot in between → rd_data_o unchanged, rd_ready_o=0 throughout.
